uart_tx_fifo_rd: RTL and testbench
==================================

Name: uart_tx_fifo_rd

Overview:
- UART transmit serializer that drains the TX FIFO through its read side. It consumes first-word-fall-through data: data is valid whenever the FIFO is not empty, and a read strobe pops on the next edge.
- Produces 8N1-style frames on the serial line, paced by an external oversampling tick from the shared baud generator.
- Sits between the AHB-written TX FIFO and the UART pad.

Parameters:
- DWIDTH, 8, data bits per frame; must match FIFO DWIDTH.
- OVERSAMPLE, 16, s_tick pulses per start/data/parity bit.
- SB_TICK, 16, s_tick pulses for the stop period (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_data  input  DWIDTH  TX FIFO head word, valid when fifo_empty=0.
- fifo_rd  output  1  pop strobe to TX FIFO, one clk wide.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while state != IDLE.
- tx_done_tick  output  1  one-clk pulse when a stop period completes.

Behaviour:
- Reset values (async, resetn=0):
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0.
  - s_cnt=0, n_cnt=0, shift register=0.
  - fifo_rd=0 (fifo_rd is combinational and low during reset).
- Registers:
  - tx is registered.
  - s_cnt is the tick counter, width clog2(max(OVERSAMPLE,SB_TICK)).
  - n_cnt is the bit index, width clog2(DWIDTH).
  - b_reg is the DWIDTH-bit shift register.
- fifo_rd = (state==IDLE) & ~fifo_empty & resetn. On that same edge: b_reg<=fifo_data, s_cnt<=0, state<=START. fifo_rd is therefore exactly one cycle per frame.
- IDLE: tx=1. s_tick is ignored. Stays in IDLE while fifo_empty=1.
- START: tx=0. On s_tick, s_cnt increments. When s_tick & s_cnt==OVERSAMPLE-1: s_cnt<=0, n_cnt<=0, state<=DATA.
- DATA: tx=b_reg[0], LSB first. On bit end (s_tick & s_cnt==OVERSAMPLE-1):
  - b_reg shifts right by 1.
  - If n_cnt==DWIDTH-1, go to STOP (or PARITY, see Optional Feature); otherwise n_cnt increments.
- STOP: tx=1. When s_tick & s_cnt==SB_TICK-1: state<=IDLE, tx_done_tick=1 for that one cycle.
- tx is updated on the state-transition edge, so the line change coincides with the registered state change. Bit boundaries are aligned to s_tick.
- Latency: the first start bit appears on tx one clk after the fifo_rd cycle. The frame lasts (1+DWIDTH)*OVERSAMPLE+SB_TICK ticks.
- Back-to-back: if fifo_empty=0 when IDLE is re-entered, the next pop occurs in that IDLE cycle. Minimum inter-frame gap is exactly 1 clk of tx=1.
- Changes on fifo_empty or fifo_data mid-frame have no effect. The frame uses the latched b_reg.
- s_tick held high continuously gives 1 tick per clk. This is legal and used in test.
- Reset asserted mid-frame: the frame is aborted, tx=1 immediately, and the popped byte is lost. No pop occurs until resetn is released and the FSM is in IDLE.
- Must not pop when fifo_empty=1, under any state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input port parity_odd (1 bit, sampled at the fifo_rd edge) and a PARITY state between DATA and STOP.
  - The parity bit is the XOR of all data bits, inverted when parity_odd=1.
  - The parity bit is computed from fifo_data at pop and held for OVERSAMPLE ticks.
  - Frame length grows by OVERSAMPLE ticks.
- Undefined: no parity_odd port and no PARITY state. DATA goes directly to STOP.

Test Plan:
- Reset: hold resetn=0 with fifo_empty=0 -> tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0 throughout.
- Single byte, s_tick=1 constant, fifo_data=0xA5, fifo_empty falls for 1 clk:
  - fifo_rd pulses exactly once.
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 clks.
  - tx_done_tick pulses once 160 clks after frame start.
  - tx_busy is high for 160 clks.
- Back-to-back: FIFO holds 0x00 then 0xFF -> two fifo_rd pulses 161 clks apart. Exactly 1 idle clk of tx=1 between the stop bit and the next start bit.
- Tick pacing: s_tick every 4th clk, byte 0x3C -> each bit 64 clks ±3 clk alignment; decoded byte is 0x3C; no pop while fifo_empty=1.
- Reset mid-DATA, asserted at bit 3 of 0x55 -> tx=1 within the reset cycle. After release the FSM is in IDLE and, if fifo_empty=0, the next byte is popped.
- Parity (UART_TX_PARITY_EN defined), byte 0x07:
  - parity_odd=0 -> parity bit 1; parity_odd=1 -> parity bit 0.
  - Frame length is 176 clks at s_tick=1.

Source files
------------

// File: rtl/uart_tx_fifo_rd.sv
// uart_tx_fifo_rd
//   UART transmit serializer that drains a first-word-fall-through TX FIFO.
//   Each frame is: start bit (0), DWIDTH data bits LSB first, optional
//   parity bit, then a stop period of SB_TICK oversampling ticks (line high).
//   All bit timing is counted in s_tick pulses from the shared baud generator.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, adds the parity_odd input and a parity bit between the
//     last data bit and the stop period.
//
// Ports
//   clk          system clock, all state on rising edge
//   resetn       asynchronous active-low reset
//   s_tick       one-clk pulse at OVERSAMPLE x baud rate
//   fifo_empty   TX FIFO empty flag
//   fifo_data    TX FIFO head word, valid while fifo_empty is low
//   parity_odd   (UART_TX_PARITY_EN only) odd parity select, sampled at pop
//   fifo_rd      one-clk pop strobe to the TX FIFO
//   tx           registered serial line, idle high
//   tx_busy      high while a frame is in progress
//   tx_done_tick one-clk pulse on the cycle the stop period completes
module uart_tx_fifo_rd #(
  parameter int DWIDTH     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_tick,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              fifo_rd,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  localparam int CMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int NW   = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     s_cnt, s_cnt_nxt;
  logic [NW-1:0]     n_cnt, n_cnt_nxt;
  logic [DWIDTH-1:0] b_reg, b_nxt;
  logic              tx_nxt;
  logic              par_reg, par_nxt;
  logic              bit_end;

  assign bit_end = s_tick && (s_cnt == OS_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      s_cnt   <= '0;
      n_cnt   <= '0;
      b_reg   <= '0;
      par_reg <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      s_cnt   <= s_cnt_nxt;
      n_cnt   <= n_cnt_nxt;
      b_reg   <= b_nxt;
      par_reg <= par_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nxt = state;
    s_cnt_nxt = s_cnt;
    n_cnt_nxt = n_cnt;
    b_nxt     = b_reg;
    par_nxt   = par_reg;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = START;
          s_cnt_nxt = '0;
          b_nxt     = fifo_data;
`ifdef UART_TX_PARITY_EN
          par_nxt   = (^fifo_data) ^ parity_odd;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_nxt = '0;
            n_cnt_nxt = '0;
            state_nxt = DATA;
          end else begin
            s_cnt_nxt = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          s_cnt_nxt = '0;
          b_nxt     = b_reg >> 1;
          if (n_cnt == N_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            n_cnt_nxt = n_cnt + 1'b1;
          end
        end else if (s_tick) begin
          s_cnt_nxt = s_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          s_cnt_nxt = '0;
          state_nxt = STOP;
        end else if (s_tick) begin
          s_cnt_nxt = s_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SB_LAST) begin
            s_cnt_nxt = '0;
            state_nxt = IDLE;
          end else begin
            s_cnt_nxt = s_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line level is derived from the state being entered so that tx
    // changes on exactly the same edge as the registered state.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = b_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Combinational outputs; fifo_rd is gated by resetn so no pop can be
  // issued while reset is held.
  always_comb begin
    fifo_rd      = (state == IDLE) && !fifo_empty && resetn;
    tx_busy      = (state != IDLE);
    tx_done_tick = (state == STOP) && s_tick && (s_cnt == SB_LAST);
  end

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
module tb_uart_tx_fifo_rd;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DW + 2;
`else
  localparam int NB = DW + 1;
`endif
  localparam int T = NB * OS + SB;  // ticks per frame

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_tick;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic          tx;
  logic          tx_busy;
  logic          tx_done_tick;
`ifdef UART_TX_PARITY_EN
  logic          parity_odd;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo_rd #(.DWIDTH(DW), .OVERSAMPLE(OS), .SB_TICK(SB)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_tick       (s_tick),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a frame is a count of ticks since the pop; the bit on
  // the line is simply tick_count / OS indexed into start/data/parity/stop.
  bit            m_active = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_byte = '0;
  logic          m_par = 1'b0;
  logic [DW-1:0] q[$];

  int cyc = 0;
  int pops, dones, busy_cnt, last_pop, pop_gap, done_cyc;
  int tick_per = 1;
  int tick_ph = 0;
  int hide_pct = 0;
  bit odd = 1'b0;

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return m_byte[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == DW + 1) return m_par;
`endif
    return 1'b1;
  endfunction

  task automatic clear_stats();
    pops = 0; dones = 0; busy_cnt = 0; last_pop = -1; pop_gap = -1; done_cyc = -1;
  endtask

  // One clock: drive at negedge, check just after, update model at posedge.
  task automatic step(input bit rst_in);
    logic exp_rd, exp_done, hide;
    resetn = rst_in;
    if (tick_per == 0) s_tick = 1'($urandom_range(0, 1));
    else begin
      s_tick  = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % tick_per;
    end
    hide = ($urandom_range(0, 99) < hide_pct);
    if (m_active) begin
      fifo_empty = 1'($urandom_range(0, 1));
      fifo_data  = DW'($urandom);
    end else begin
      fifo_empty = (q.size() == 0) || hide;
      fifo_data  = fifo_empty ? DW'($urandom) : q[0];
    end
`ifdef UART_TX_PARITY_EN
    parity_odd = (!m_active && !fifo_empty) ? odd : 1'($urandom_range(0, 1));
`endif
    if (!rst_in) m_active = 1'b0;
    #1;
    exp_rd   = !m_active && !fifo_empty && rst_in;
    exp_done = m_active && s_tick && (m_t + 1 == T);
    chk("tx", tx, exp_tx());
    chk("fifo_rd", fifo_rd, exp_rd);
    chk("tx_busy", tx_busy, m_active);
    chk("tx_done_tick", tx_done_tick, exp_done);
    if (fifo_rd === 1'b1) begin
      pops++;
      if (last_pop >= 0) pop_gap = cyc - last_pop;
      last_pop = cyc;
    end
    if (tx_done_tick === 1'b1) begin dones++; done_cyc = cyc; end
    if (tx_busy === 1'b1) busy_cnt++;
    @(posedge clk);
    if (exp_rd) begin
      m_active = 1'b1;
      m_t      = 0;
      m_byte   = fifo_data;
`ifdef UART_TX_PARITY_EN
      m_par    = (^fifo_data) ^ parity_odd;
`endif
      void'(q.pop_front());
    end else if (m_active && s_tick) begin
      m_t++;
      if (m_t == T) m_active = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((m_active || q.size() != 0) && n < maxc) begin
      step(1'b1);
      n++;
    end
    chk("drain_timeout", 32'(m_active || q.size() != 0), 0);
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    resetn = 1'b0; s_tick = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif
    @(negedge clk);

    // Reset held with a non-empty FIFO: no pop, idle line
    clear_stats();
    q.push_back(8'h11);
    tick_per = 1; tick_ph = 0; hide_pct = 0;
    repeat (6) step(1'b0);
    chk("reset_pops", pops, 0);
    q.delete();
    repeat (3) step(1'b1);

    // Single byte 0xA5 with s_tick held high
    clear_stats();
    q.push_back(8'hA5);
    drain(400);
    chk("a5_pops", pops, 1);
    chk("a5_dones", dones, 1);
    chk("a5_done_latency", done_cyc - last_pop, T);
    chk("a5_busy_len", busy_cnt, T);

    // Back-to-back 0x00 then 0xFF
    clear_stats();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    drain(800);
    chk("b2b_pops", pops, 2);
    chk("b2b_gap", pop_gap, T + 1);
    chk("b2b_busy_len", busy_cnt, 2 * T);

    // Tick every 4th clock, byte 0x3C, FIFO sometimes reported empty
    clear_stats();
    tick_per = 4; tick_ph = 0; hide_pct = 30;
    repeat (10) step(1'b1);
    q.push_back(8'h3C);
    drain(3000);
    chk("tick4_pops", pops, 1);
    chk("tick4_busy_range", 32'(busy_cnt >= 4 * T - 3 && busy_cnt <= 4 * T + 3), 1);

    // Reset during data bit 3 of 0x55; byte lost, next byte popped after
    clear_stats();
    tick_per = 1; tick_ph = 0; hide_pct = 0;
    q.push_back(8'h55);
    q.push_back(8'h12);
    while (!m_active) step(1'b1);
    repeat (OS + 3 * OS + 5) step(1'b1);
    repeat (3) step(1'b0);
    chk("abort_queue", q.size(), 1);
    drain(400);
    chk("abort_pops", pops, 2);
    chk("abort_dones", dones, 1);

`ifdef UART_TX_PARITY_EN
    // Parity on 0x07, even then odd
    clear_stats();
    odd = 1'b0;
    q.push_back(8'h07);
    drain(400);
    chk("par_even_latency", done_cyc - last_pop, T);
    clear_stats();
    odd = 1'b1;
    q.push_back(8'h07);
    drain(400);
    chk("par_odd_latency", done_cyc - last_pop, T);
`endif

    // Randomized frames with mixed tick pacing and FIFO gaps
    for (int i = 0; i < 12; i++) begin
      clear_stats();
      tick_per = $urandom_range(0, 3);
      tick_ph  = 0;
      hide_pct = $urandom_range(0, 50);
      odd      = 1'($urandom_range(0, 1));
      q.push_back(DW'($urandom));
      if ($urandom_range(0, 1) == 1) q.push_back(DW'($urandom));
      drain(6000);
      chk("rand_dones", dones, pops);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
